// File: rtl/muldiv_pkg.sv
// Shared constants and state encoding for the multiply/divide sequencer.
// MULT/DIV codes and the FIX state are used only when MULDIV_SIGNED_EN is defined.
package muldiv_pkg;

  localparam int ITER = 32;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] DIV   = 6'b011010;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
`ifdef MULDIV_SIGNED_EN
    S_FIX  = 3'd3,
`endif
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_addsub.sv
// Adder/subtractor shared by the multiply and divide iterations.
// sub=1 computes a + ~b + 1.
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  assign y = a + (sub ? ~b : b) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULTU/DIVU sequencer with HI/LO result registers.
// Define MULDIV_SIGNED_EN to also accept MULT/DIV (adds a one-cycle FIX state).
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER);

  state_t           state, state_nxt, fin_state;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] hi_nxt, lo_nxt, m, m_nxt;
  logic [WIDTH-1:0] opa, opb, hs;
  logic [WIDTH:0]   add_a, add_y, sum;
  logic             op_sgn, op_mul, op_div, is_sub;

`ifdef MULDIV_SIGNED_EN
  logic               sa, sa_nxt, neg, neg_nxt, fdiv, fdiv_nxt;
  logic [2*WIDTH-1:0] prod_neg;

  assign op_sgn    = (funct == MULT) || (funct == DIV);
  // Iterate on magnitudes; signs are reapplied in FIX.
  assign opa       = (op_sgn && dataA[WIDTH-1]) ? -dataA : dataA;
  assign opb       = (op_sgn && dataB[WIDTH-1]) ? -dataB : dataB;
  assign fin_state = neg || sa ? S_FIX : S_DONE;
  assign prod_neg  = -{hi, lo};
`else
  assign op_sgn    = 1'b0;
  assign opa       = dataA;
  assign opb       = dataB;
  assign fin_state = S_DONE;
`endif

  assign op_mul = (funct == MULTU) || (op_sgn && funct == MULT);
  assign op_div = (funct == DIVU)  || (op_sgn && funct == DIV);

  // Remainder shifted left; hi[WIDTH-1] rides in the adder's top bit so
  // divisors above 2^(WIDTH-1) still compare correctly.
  assign hs     = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign is_sub = (state == S_DIV);
  assign add_a  = is_sub ? {hi[WIDTH-1], hs} : {1'b0, hi};
  assign sum    = lo[0] ? add_y : {1'b0, hi};

  muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
    .a   (add_a),
    .b   ({1'b0, m}),
    .sub (is_sub),
    .y   (add_y)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi;
    lo_nxt    = lo;
    m_nxt     = m;
`ifdef MULDIV_SIGNED_EN
    sa_nxt    = sa;
    neg_nxt   = neg;
    fdiv_nxt  = fdiv;
`endif
    case (state)
      S_IDLE: begin
        if (start && (op_mul || op_div)) begin
`ifdef MULDIV_SIGNED_EN
          sa_nxt   = op_sgn & dataA[WIDTH-1];
          neg_nxt  = op_sgn & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
          fdiv_nxt = op_div;
`endif
          if (op_div && dataB == '0) begin
            // Divide by zero: raw result, no iterations and no sign fix.
            state_nxt = S_DONE;
            hi_nxt    = dataA;
            lo_nxt    = '1;
`ifdef MULDIV_SIGNED_EN
            sa_nxt    = 1'b0;
            neg_nxt   = 1'b0;
`endif
          end else begin
            state_nxt = op_mul ? S_MUL : S_DIV;
            cnt_nxt   = CW'(ITER - 1);
            hi_nxt    = '0;
            lo_nxt    = opa;
            m_nxt     = opb;
          end
        end
      end
      S_MUL: begin
        {hi_nxt, lo_nxt} = {sum, lo[WIDTH-1:1]};
        if (cnt == '0) state_nxt = fin_state;
        else           cnt_nxt   = cnt - CW'(1);
      end
      S_DIV: begin
        hi_nxt = add_y[WIDTH] ? hs : add_y[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], ~add_y[WIDTH]};
        if (cnt == '0) state_nxt = fin_state;
        else           cnt_nxt   = cnt - CW'(1);
      end
`ifdef MULDIV_SIGNED_EN
      S_FIX: begin
        if (fdiv) begin
          lo_nxt = neg ? -lo : lo;
          hi_nxt = sa ? -hi : hi;
        end else if (neg) begin
          {hi_nxt, lo_nxt} = prod_neg;
        end
        state_nxt = S_DONE;
      end
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      m     <= '0;
`ifdef MULDIV_SIGNED_EN
      sa    <= 1'b0;
      neg   <= 1'b0;
      fdiv  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      m     <= m_nxt;
`ifdef MULDIV_SIGNED_EN
      sa    <= sa_nxt;
      neg   <= neg_nxt;
      fdiv  <= fdiv_nxt;
`endif
    end
  end

  assign busy = (state == S_MUL) || (state == S_DIV);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: vector table plus overlap/reset sequences.
module tb_muldiv_ctrl;

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic        clk, reset, start, busy, done;
  logic [5:0]  funct;
  logic [31:0] dataA, dataB, hi, lo;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a, b, ehi, elo;
    int          ecyc, ebusy;
  } vec_t;

  vec_t vecs[11];

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .funct (funct),
    .dataA (dataA),
    .dataB (dataB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  // Issue one request, watch 40 cycles; optionally inject a second start or a reset.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int inj_cyc, input int rst_cyc,
                        output int dcyc, output int bcnt, output int both,
                        output logic [31:0] h, output logic [31:0] l);
    dcyc = 0; bcnt = 0; both = 0; h = '0; l = '0;
    @(negedge clk);
    funct = f; dataA = a; dataB = b; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 40; c++) begin
      if (c == inj_cyc) begin
        start = 1'b1; funct = F_DIVU; dataA = 32'd50; dataB = 32'd5;
      end else begin
        start = 1'b0;
      end
      if (c == rst_cyc) begin
        reset = 1'b1; #1; reset = 1'b0; #1;
      end
      if (busy) bcnt++;
      if (busy && done) both++;
      if (done && dcyc == 0) begin
        dcyc = c; h = hi; l = lo;
      end
      @(posedge clk); #1;
    end
    if (dcyc == 0) begin
      h = hi; l = lo;
    end
  endtask

  int          dcyc, bcnt, both;
  logic [31:0] h, l;

  initial begin
    reset = 1'b1; start = 1'b0; funct = '0; dataA = '0; dataB = '0;

    vecs[0] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 32};
    vecs[1] = '{F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33, 32};
    vecs[2] = '{F_DIVU,  32'd5,        32'd9,        32'd5,        32'd0,        33, 32};
    vecs[3] = '{F_DIVU,  32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 1,  0};
    vecs[4] = '{F_ADD,   32'd7,        32'd9,        32'h1234,     32'hFFFFFFFF, 0,  0};
    vecs[5] = '{F_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 33, 32};
    vecs[6] = '{F_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 33, 32};
    vecs[7] = '{F_MULTU, 32'hDEADBEEF, 32'd0,        32'd0,        32'd0,        33, 32};
`ifdef MULDIV_SIGNED_EN
    vecs[8]  = '{F_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34, 32};
    vecs[9]  = '{F_MULT, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 34, 32};
    vecs[10] = '{F_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1,  0};
`else
    vecs[8]  = '{F_MULT, 32'd3,        32'd5,        32'd0,        32'd0,        0,  0};
    vecs[9]  = '{F_DIV,  32'd7,        32'd2,        32'd0,        32'd0,        0,  0};
    vecs[10] = '{F_MULTU, 32'd7,       32'd6,        32'd0,        32'd42,       33, 32};
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, 0, 0, dcyc, bcnt, both, h, l);
      chk($sformatf("v%0d_done_cyc", i), dcyc, vecs[i].ecyc);
      chk($sformatf("v%0d_busy_cnt", i), bcnt, vecs[i].ebusy);
      chk($sformatf("v%0d_overlap", i), both, 32'd0);
      chk($sformatf("v%0d_hi", i), h, vecs[i].ehi);
      chk($sformatf("v%0d_lo", i), l, vecs[i].elo);
    end

    // Second start mid-multiply must be dropped.
    run_op(F_MULTU, 32'd3, 32'd4, 10, 0, dcyc, bcnt, both, h, l);
    chk("inj_done_cyc", dcyc, 32'd33);
    chk("inj_busy_cnt", bcnt, 32'd32);
    chk("inj_hi", h, 32'd0);
    chk("inj_lo", l, 32'd12);
    chk("inj_final_lo", lo, 32'd12);

    // Reset in cycle 15 of a divide aborts it silently.
    run_op(F_DIVU, 32'd1000, 32'd3, 0, 15, dcyc, bcnt, both, h, l);
    chk("rst_mid_done", dcyc, 32'd0);
    chk("rst_mid_busy", bcnt, 32'd14);
    chk("rst_mid_hi", h, 32'd0);
    chk("rst_mid_lo", l, 32'd0);

    run_op(F_MULTU, 32'd2, 32'd2, 0, 0, dcyc, bcnt, both, h, l);
    chk("post_rst_cyc", dcyc, 32'd33);
    chk("post_rst_hi", h, 32'd0);
    chk("post_rst_lo", l, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
